// File: rtl/rgb_to_hsx_pipe.sv
// RGB to HSL/HSV pixel converter; mode and sideband tag travel with each pixel.
// Latency: FRAC+5 cycles from input transfer to out_valid when never stalled.
// Backpressure: single advance enable (!out_valid | out_ready) freezes every stage together.
module rgb_to_hsx_pipe #(
    parameter int DW    = 8,
    parameter int OW    = 8,
    parameter int SCALE = 240,
    parameter int FRAC  = 10,
    parameter int UW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_mode,
    input  logic [UW-1:0] in_user,
    input  logic [DW-1:0] R,
    input  logic [DW-1:0] G,
    input  logic [DW-1:0] B,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] H,
    output logic [OW-1:0] S,
    output logic [OW-1:0] X,
    output logic          out_mode,
    output logic [UW-1:0] out_user
);
    localparam int NST = FRAC + 1;                    // divider stages
    localparam int PW  = $clog2(SCALE + 1) + FRAC + 1; // scaled fixed-point width with headroom
    localparam int XW  = DW + FRAC + 1;

    localparam logic [DW:0]    FULL_S   = {1'b0, {DW{1'b1}}};
    localparam logic [DW:0]    TWO_FULL = {{DW{1'b1}}, 1'b0};
    localparam logic [XW-1:0]  FULL_X   = XW'((1 << DW) - 1);
    localparam logic [PW-1:0]  HALF     = PW'(1) << (FRAC - 1);
    localparam logic [PW-1:0]  SCL      = PW'(SCALE);
    localparam logic [PW-1:0]  SIXTH    = PW'(SCALE / 6);
    localparam logic [PW-1:0]  OFF1     = PW'(SCALE / 3) << FRAC;
    localparam logic [PW-1:0]  OFF2     = PW'(2 * SCALE / 3) << FRAC;
    localparam logic [PW-1:0]  WRAP     = SCL << FRAC;

    typedef struct packed {
        logic [1:0]    sec;
        logic          hneg;
        logic          mode;
        logic [UW-1:0] user;
        logic [FRAC:0] qx;
    } side_t;

    // Two restoring dividers side by side: s = saturation, h = hue fraction.
    typedef struct packed {
        logic [DW:0]   rs;
        logic [DW:0]   rh;
        logic [DW-1:0] ds;
        logic [DW-1:0] dh;
        logic [FRAC:0] qs;
        logic [FRAC:0] qh;
    } div_t;

    function automatic div_t div_step(input div_t d, input logic first);
        logic [DW:0] ts;
        logic [DW:0] th;
        div_t        n;
        n  = d;
        ts = first ? d.rs : (d.rs << 1);
        th = first ? d.rh : (d.rh << 1);
        if (ts >= {1'b0, d.ds}) begin
            n.rs = ts - {1'b0, d.ds};
            n.qs = {d.qs[FRAC-1:0], 1'b1};
        end else begin
            n.rs = ts;
            n.qs = {d.qs[FRAC-1:0], 1'b0};
        end
        if (th >= {1'b0, d.dh}) begin
            n.rh = th - {1'b0, d.dh};
            n.qh = {d.qh[FRAC-1:0], 1'b1};
        end else begin
            n.rh = th;
            n.qh = {d.qh[FRAC-1:0], 1'b0};
        end
        return n;
    endfunction

    function automatic logic [OW-1:0] rnd(input logic [PW-1:0] v);
        logic [PW-1:0] t;
        t = v + HALF;
        return OW'(t >> FRAC);
    endfunction

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // stage 1: extremes, sector (ties R > G > B) and signed hue numerator
    logic [1:0]    sec_c, sec1;
    logic          hneg_c, hneg1, v1, mode1;
    logic [DW-1:0] mx_c, mn_c, hm_c, mx1, mn1, hm1;
    logic [UW-1:0] user1;

    // Pick max/min and the hue numerator of the winning sector.
    always_comb begin
        sec_c  = 2'd0;
        mx_c   = R;
        mn_c   = (G < B) ? G : B;
        hneg_c = (G < B);
        hm_c   = hneg_c ? (B - G) : (G - B);
        if (!(R >= G && R >= B)) begin
            if (G >= B) begin
                sec_c  = 2'd1;
                mx_c   = G;
                mn_c   = (R < B) ? R : B;
                hneg_c = (B < R);
                hm_c   = hneg_c ? (R - B) : (B - R);
            end else begin
                sec_c  = 2'd2;
                mx_c   = B;
                mn_c   = (R < G) ? R : G;
                hneg_c = (R < G);
                hm_c   = hneg_c ? (G - R) : (R - G);
            end
        end
    end

    // stage 2: divider operands; zero divisors only occur with a zero numerator, so feed 1
    logic [DW-1:0] diff_c;
    logic [DW:0]   sum_c, denl_c;
    logic [XW-1:0] xnum_c;
    div_t          div_c, div2;
    side_t         side_c, side2;
    logic          v2;

    // HSL lightness uses sum/(2*FULL) == (sum*2^(FRAC-1))/FULL, so one constant divisor covers both modes.
    always_comb begin
        diff_c   = mx1 - mn1;
        sum_c    = {1'b0, mx1} + {1'b0, mn1};
        denl_c   = (sum_c <= FULL_S) ? sum_c : (TWO_FULL - sum_c);
        div_c    = '0;
        div_c.rs = {1'b0, diff_c};
        div_c.rh = {1'b0, hm1};
        div_c.ds = mode1 ? mx1 : denl_c[DW-1:0];
        if (div_c.ds == '0) div_c.ds = DW'(1);
        div_c.dh = (diff_c == '0) ? DW'(1) : diff_c;
        xnum_c   = mode1 ? (XW'(mx1) << FRAC) : (XW'(sum_c) << (FRAC - 1));
        side_c.sec  = sec1;
        side_c.hneg = hneg1;
        side_c.mode = mode1;
        side_c.user = user1;
        side_c.qx   = NST'(xnum_c / FULL_X);
    end

    // divider stages: one quotient bit each, MSB (integer bit) first
    logic [NST-1:0] vd;
    side_t          sd [NST];
    div_t           dd [NST];
    div_t           dn [NST];

    // Next value of every divider stage.
    always_comb begin
        dn[0] = div_step(div2, 1'b1);
        for (int j = 1; j < NST; j++) dn[j] = div_step(dd[j-1], 1'b0);
    end

    // stage 14: scale quotients and place hue in its sector, folding negatives by one turn
    logic [PW-1:0] off_c, p_c, hr_c, xp14, sp14, hr14;
    logic          v14, mode14;
    logic [UW-1:0] user14;
    logic [OW-1:0] h_c;

    // Hue offset plus signed fraction, wrapped into [0, SCALE*2^FRAC).
    always_comb begin
        case (sd[NST-1].sec)
            2'd1:    off_c = OFF1;
            2'd2:    off_c = OFF2;
            default: off_c = '0;
        endcase
        p_c = PW'(dd[NST-1].qh) * SIXTH;
        if (!sd[NST-1].hneg)    hr_c = off_c + p_c;
        else if (off_c >= p_c)  hr_c = off_c - p_c;
        else                    hr_c = off_c + WRAP - p_c;
    end

    // Rounded hue can land on SCALE exactly; fold that to 0.
    always_comb begin
        h_c = rnd(hr14);
        if (h_c >= OW'(SCALE)) h_c = h_c - OW'(SCALE);
    end

    // All pipeline registers, moving only when the output is free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0; mode1 <= 1'b0; user1 <= '0; sec1 <= '0; hneg1 <= 1'b0;
            mx1 <= '0; mn1 <= '0; hm1 <= '0;
            v2 <= 1'b0; side2 <= '0; div2 <= '0;
            vd <= '0;
            for (int j = 0; j < NST; j++) begin
                sd[j] <= '0;
                dd[j] <= '0;
            end
            v14 <= 1'b0; mode14 <= 1'b0; user14 <= '0; xp14 <= '0; sp14 <= '0; hr14 <= '0;
            out_valid <= 1'b0; H <= '0; S <= '0; X <= '0; out_mode <= 1'b0; out_user <= '0;
        end else if (adv) begin
            v1 <= in_valid; mode1 <= in_mode; user1 <= in_user; sec1 <= sec_c; hneg1 <= hneg_c;
            mx1 <= mx_c; mn1 <= mn_c; hm1 <= hm_c;
            v2 <= v1; side2 <= side_c; div2 <= div_c;
            vd    <= {vd[NST-2:0], v2};
            sd[0] <= side2;
            dd[0] <= dn[0];
            for (int j = 1; j < NST; j++) begin
                sd[j] <= sd[j-1];
                dd[j] <= dn[j];
            end
            v14    <= vd[NST-1];
            mode14 <= sd[NST-1].mode;
            user14 <= sd[NST-1].user;
            xp14   <= PW'(sd[NST-1].qx) * SCL;
            sp14   <= PW'(dd[NST-1].qs) * SCL;
            hr14   <= hr_c;
            out_valid <= v14;
            H         <= h_c;
            S         <= rnd(sp14);
            X         <= rnd(xp14);
            out_mode  <= mode14;
            out_user  <= user14;
        end
    end
endmodule

// File: tb/tb_rgb_to_hsx_pipe.sv
// Randomized and directed bench for rgb_to_hsx_pipe against an integer reference model.
// Latency: checks exact 15-cycle latency whenever out_ready is held high.
// Backpressure: stalls, out_ready toggling and mid-stream async reset are exercised.
module tb_rgb_to_hsx_pipe;
    localparam int LAT   = 15;
    localparam int FULL  = 255;
    localparam int SCALE = 240;
    localparam int FRAC  = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid = 1'b0, in_ready, in_mode = 1'b0;
    logic [1:0] in_user = '0;
    logic [7:0] R = '0, G = '0, B = '0;
    logic       out_valid, out_ready = 1'b1, out_mode;
    logic [7:0] H, S, X;
    logic [1:0] out_user;

    rgb_to_hsx_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_user(in_user), .R(R), .G(G), .B(B),
        .out_valid(out_valid), .out_ready(out_ready), .H(H), .S(S), .X(X),
        .out_mode(out_mode), .out_user(out_user)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         h, s, x;
        bit         m;
        logic [1:0] u;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_cmp = 0, n_err = 0;
    bit   chk_lat = 1'b1;
    bit   tog_done;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int qdiv(input int n, input int d);
        return (n * (1 << FRAC)) / d;
    endfunction

    function automatic int rnd(input int v);
        return (v + (1 << (FRAC - 1))) / (1 << FRAC);
    endfunction

    // Reference conversion straight from the colour-space definitions.
    task automatic model(input int r, g, b, input bit m, output int h, s, x);
        int mx, mn, diff, sum, hp, off, den, p, hr, mag;
        mx = (r > g) ? r : g;  mx = (mx > b) ? mx : b;
        mn = (r < g) ? r : g;  mn = (mn < b) ? mn : b;
        diff = mx - mn;
        sum  = mx + mn;
        if (r == mx)      begin hp = g - b; off = 0; end
        else if (g == mx) begin hp = b - r; off = SCALE / 3; end
        else              begin hp = r - g; off = 2 * SCALE / 3; end
        x = m ? rnd(qdiv(mx, FULL) * SCALE) : rnd(qdiv(sum, 2 * FULL) * SCALE);
        if (diff == 0) begin
            h = 0;
            s = 0;
        end else begin
            den = m ? mx : ((sum <= FULL) ? sum : 2 * FULL - sum);
            s   = rnd(qdiv(diff, den) * SCALE);
            mag = (hp < 0) ? -hp : hp;
            p   = qdiv(mag, diff) * (SCALE / 6);
            hr  = off * (1 << FRAC) + ((hp < 0) ? -p : p);
            if (hr < 0) hr += SCALE * (1 << FRAC);
            h = rnd(hr);
            if (h >= SCALE) h -= SCALE;
        end
    endtask

    // Output monitor: every transferred pixel must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            chk("out_has_pending", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("H", H, e.h);
                chk("S", S, e.s);
                chk("X", X, e.x);
                chk("out_mode", out_mode, e.m);
                chk("out_user", out_user, e.u);
                if (chk_lat) chk("latency", cyc - e.cyc, LAT);
            end
        end
    end

    // Starts and ends at posedge+1; holds the pixel until it is accepted.
    task automatic send_exp(input int r, g, b, input bit m, input logic [1:0] u,
                            input int eh, es, ex);
        exp_t e;
        int   n;
        R = 8'(r); G = 8'(g); B = 8'(b);
        in_mode = m; in_user = u; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (in_ready) begin
            e.h = eh; e.s = es; e.x = ex; e.m = m; e.u = u; e.cyc = cyc;
            sb.push_back(e);
        end else begin
            chk("send_accept", in_ready, 1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_mdl(input int r, g, b, input bit m, input logic [1:0] u);
        int h, s, x;
        model(r, g, b, m, h, s, x);
        send_exp(r, g, b, m, u, h, s, x);
    endtask

    function automatic int rcomp();
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return 255;
            2:       return 128;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    task automatic send_rand(input bit m);
        send_mdl(rcomp(), rcomp(), rcomp(), m, 2'($urandom_range(0, 3)));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int seen;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_H", H, 0);
        chk("rst_S", S, 0);
        chk("rst_X", X, 0);
        chk("rst_out_user", out_user, 0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors with literal expectations.
        send_exp(128, 128, 128, 1'b0, 2'd0, 0,   0,   120);
        send_exp(255,   0,   0, 1'b0, 2'd1, 0,   240, 120);
        send_exp(  0, 255,   0, 1'b0, 2'd2, 80,  240, 120);
        send_exp(  0,   0, 255, 1'b0, 2'd3, 160, 240, 120);
        send_exp(255,   0,  10, 1'b0, 2'd0, 238, 240, 120);
        send_exp(  0,   0,   0, 1'b0, 2'd1, 0,   0,   0);
        send_exp(255, 255, 255, 1'b0, 2'd2, 0,   0,   240);
        send_exp(200, 100,  50, 1'b1, 2'd3, 13,  180, 188);
        send_exp(  0,   0,   0, 1'b1, 2'd0, 0,   0,   0);
        send_exp(255, 255, 255, 1'b1, 2'd1, 0,   0,   240);
        drain();

        // Mode alternating on consecutive pixels.
        for (int i = 0; i < 12; i++) send_rand(1'(i % 2));
        drain();

        // Random stream with random bubbles, out_ready held high.
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
            end
            send_rand(1'($urandom_range(0, 1)));
        end
        drain();

        // Backpressure: five pixels in flight, output held for 20 cycles.
        chk_lat = 1'b0;
        for (int i = 0; i < 5; i++) send_rand(1'($urandom_range(0, 1)));
        out_ready = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) begin
                seen++;
                chk("bp_in_ready", in_ready, 0);
                chk("bp_H_hold", H, sb[0].h);
                chk("bp_S_hold", S, sb[0].s);
                chk("bp_X_hold", X, sb[0].x);
                chk("bp_user_hold", out_user, sb[0].u);
            end
        end
        chk("bp_output_seen", seen > 0, 1);
        chk("bp_queue_full", sb.size(), 5);
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain();

        // out_ready toggling every cycle while pixels stream in.
        tog_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++) send_rand(1'($urandom_range(0, 1)));
                tog_done = 1'b1;
            end
            begin
                while (!tog_done) begin
                    @(posedge clk); #1;
                    out_ready = ~out_ready;
                end
            end
        join
        out_ready = 1'b1;
        drain();
        chk_lat = 1'b1;

        // Asynchronous reset with pixels in flight.
        for (int i = 0; i < 8; i++) send_rand(1'($urandom_range(0, 1)));
        seen = 0;
        while (!out_valid && seen < 30) begin
            @(negedge clk);
            seen++;
        end
        chk("pre_reset_out_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_H", H, 0);
        chk("arst_S", S, 0);
        chk("arst_X", X, 0);
        chk("arst_out_mode", out_mode, 0);
        chk("arst_out_user", out_user, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (LAT + 2) begin
            @(negedge clk);
            chk("no_stale_out", out_valid, 0);
        end
        @(posedge clk); #1;
        send_exp(0, 255, 0, 1'b0, 2'd2, 80, 240, 120);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
